// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: PC update port, instruction memory handshake,
// decode handshake and execute-side redirect/halt controls.
`timescale 1ns/1ps
interface fetch_unit_if #(
  parameter int POINTER_LEN = 16,
  parameter int DATA_LEN    = 16
);
  logic [POINTER_LEN-1:0] instruction_ptr;
  logic                   pc_wr_en;
  logic                   pc_src;
  logic [DATA_LEN-1:0]    pc_data;
  logic                   imem_req;
  logic [POINTER_LEN-1:0] imem_addr;
  logic                   imem_ack;
  logic [DATA_LEN-1:0]    imem_rdata;
  logic [DATA_LEN-1:0]    ir;
  logic                   ir_valid;
  logic                   ir_ready;
  logic                   redirect;
  logic [DATA_LEN-1:0]    redirect_target;
  logic                   halt;
  logic                   fetch_err;

  modport master (
    input  instruction_ptr, imem_ack, imem_rdata, ir_ready, redirect,
           redirect_target, halt,
    output pc_wr_en, pc_src, pc_data, imem_req, imem_addr, ir, ir_valid,
           fetch_err
  );

  modport slave (
    output instruction_ptr, imem_ack, imem_rdata, ir_ready, redirect,
           redirect_target, halt,
    input  pc_wr_en, pc_src, pc_data, imem_req, imem_addr, ir, ir_valid,
           fetch_err
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: fetch -> hold for decode -> PC increment, with
// redirect/drain/load/settle handling. Optional FETCH_TIMEOUT_EN adds an ack timeout.
`timescale 1ns/1ps
module fetch_unit #(
  parameter int POINTER_LEN     = 16,
  parameter int DATA_LEN        = 16,
  parameter int REDIRECT_SETTLE = 2,
  parameter int TIMEOUT         = 64
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_HOLD, S_INC, S_DRAIN, S_LOAD, S_SETTLE
  } state_t;

  // One counter serves both SETTLE and the ack timeout; they never overlap.
  localparam int CNT_MAX = (REDIRECT_SETTLE > TIMEOUT) ? REDIRECT_SETTLE : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t                 state_q, state_d;
  logic [POINTER_LEN-1:0] addr_q, addr_d;
  logic [DATA_LEN-1:0]    ir_q, ir_d;
  logic [DATA_LEN-1:0]    tgt_q, tgt_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   err_q, err_d;
  logic                   settle_done;

  assign settle_done = (int'(cnt_q) + 1) >= REDIRECT_SETTLE;

`ifdef FETCH_TIMEOUT_EN
  logic tmo_hit;
  assign tmo_hit = (int'(cnt_q) + 1) >= TIMEOUT;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      ir_q    <= '0;
      tgt_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    tgt_d   = tgt_q;
    cnt_d   = '0;
    err_d   = err_q;

    // The newest redirect target always wins, whatever the state.
    if (bus.redirect) tgt_d = bus.redirect_target;

    unique case (state_q)
      S_IDLE: begin
        if (bus.redirect) begin
          state_d = S_LOAD;
        end else if (!bus.halt) begin
          state_d = S_FETCH;
          addr_d  = bus.instruction_ptr;
        end
      end
      S_FETCH: begin
        if (bus.imem_ack) begin
          if (bus.redirect) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_HOLD;
            ir_d    = bus.imem_rdata;
          end
        end
`ifdef FETCH_TIMEOUT_EN
        else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = bus.redirect ? S_LOAD : S_IDLE;
        end
`endif
        else if (bus.redirect) begin
          state_d = S_DRAIN;
        end
      end
      S_HOLD: begin
        if (bus.redirect)      state_d = S_LOAD;
        else if (bus.ir_ready) state_d = S_INC;
      end
      S_INC: state_d = bus.redirect ? S_LOAD : S_IDLE;
      S_DRAIN: begin
        if (bus.imem_ack) begin
          state_d = S_LOAD;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = S_LOAD;
        end
`endif
      end
      S_LOAD: state_d = bus.redirect ? S_LOAD : S_SETTLE;
      S_SETTLE: begin
        if (bus.redirect)     state_d = S_LOAD;
        else if (settle_done) state_d = S_IDLE;
        else                  cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef FETCH_TIMEOUT_EN
    if ((state_q == S_FETCH || state_q == S_DRAIN) &&
        (state_d == S_FETCH || state_d == S_DRAIN))
      cnt_d = cnt_q + 1'b1;
`endif
  end

  assign bus.imem_req  = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign bus.imem_addr = addr_q;
  assign bus.ir        = ir_q;
  assign bus.ir_valid  = (state_q == S_HOLD);
  assign bus.pc_wr_en  = (state_q == S_INC) || (state_q == S_LOAD);
  assign bus.pc_src    = (state_q == S_LOAD);
  assign bus.pc_data   = (state_q == S_LOAD) ? tgt_q : '0;
  assign bus.fetch_err = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table of normal fetches against a PC model,
// then hand-written redirect, halt, reset and timeout sequences.
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam int PL = 16;
  localparam int DL = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.POINTER_LEN(PL), .DATA_LEN(DL)) bus();

  fetch_unit #(
    .POINTER_LEN(PL), .DATA_LEN(DL), .REDIRECT_SETTLE(2), .TIMEOUT(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Program counter model plus protocol monitors
  logic [15:0] pc_q;
  logic        wr_prev;
  int          inc_cnt = 0;
  int          viol = 0;
  int          dead_seen = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= 16'h0;
      wr_prev <= 1'b0;
    end else begin
      wr_prev <= bus.pc_wr_en;
      if (bus.pc_wr_en) pc_q <= bus.pc_src ? bus.pc_data : pc_q + 16'd1;
      if (bus.pc_wr_en && !bus.pc_src) inc_cnt <= inc_cnt + 1;
      if (!bus.pc_wr_en && (bus.pc_src || bus.pc_data != 16'h0)) viol <= viol + 1;
      if (wr_prev && bus.pc_wr_en && !bus.pc_src) viol <= viol + 1;
      if (bus.ir_valid && bus.ir == 16'hDEAD) dead_seen <= dead_seen + 1;
    end
  end
  assign bus.instruction_ptr = pc_q;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] rdata;
    int          ack_dly;
    int          rdy_dly;
  } vec_t;
  vec_t vecs[20];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic wait_req();
    int n = 0;
    while (!bus.imem_req && n < 20) begin
      tick();
      n++;
    end
    chk("req_seen", bus.imem_req, 1);
  endtask

  task automatic do_fetch(input logic [15:0] addr, input logic [15:0] rdata,
                          input int ack_dly, input int rdy_dly);
    wait_req();
    chk("imem_addr", bus.imem_addr, addr);
    for (int k = 0; k < ack_dly; k++) tick();
    chk("req_addr_stable", {bus.imem_req, bus.imem_addr}, {1'b1, addr});
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = rdata;
    tick();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 16'h0;
    chk("ir_valid", bus.ir_valid, 1);
    chk("ir", bus.ir, rdata);
    for (int k = 0; k < rdy_dly; k++) begin
      tick();
      chk("hold_stable", {bus.ir_valid, bus.ir, bus.pc_wr_en}, {1'b1, rdata, 1'b0});
    end
    bus.ir_ready = 1'b1;
    tick();
    bus.ir_ready = 1'b0;
    chk("inc_pulse", {bus.ir_valid, bus.pc_wr_en, bus.pc_src, bus.pc_data}, {3'b010, 16'h0});
    tick();
    chk("inc_single", bus.pc_wr_en, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int nreq;

    bus.imem_ack        = 1'b0;
    bus.imem_rdata      = 16'h0;
    bus.ir_ready        = 1'b0;
    bus.redirect        = 1'b0;
    bus.redirect_target = 16'h0;
    bus.halt            = 1'b0;

    for (int i = 0; i < 20; i++) begin
      vecs[i].addr    = 16'(i);
      vecs[i].rdata   = 16'hA5A5 + 16'(i * 257);
      vecs[i].ack_dly = 0;
      vecs[i].rdy_dly = 0;
    end
    vecs[3].rdy_dly = 5;
    vecs[5].ack_dly = 3;
    vecs[8].ack_dly = 1;
    vecs[9].rdy_dly = 2;

    // Reset: everything low
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("rst_ctl", {bus.imem_req, bus.ir_valid, bus.pc_wr_en, bus.pc_src, bus.fetch_err}, 0);
      chk("rst_data", {bus.imem_addr, bus.ir, bus.pc_data}, 0);
    end
    rst = 1'b1;

    n0 = inc_cnt;
    for (int i = 0; i < 20; i++)
      do_fetch(vecs[i].addr, vecs[i].rdata, vecs[i].ack_dly, vecs[i].rdy_dly);
    chk("inc_count", inc_cnt - n0, 20);
    chk("pc_after_20", pc_q, 16'h0014);

    // Redirect in HOLD with same-cycle ir_ready
    wait_req();
    chk("rdh_addr", bus.imem_addr, 16'h0014);
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'h1234;
    tick();
    bus.imem_ack = 1'b0;
    chk("rdh_valid", {bus.ir_valid, bus.ir}, {1'b1, 16'h1234});
    n0 = inc_cnt;
    bus.redirect = 1'b1; bus.redirect_target = 16'h0040; bus.ir_ready = 1'b1;
    tick();
    bus.redirect = 1'b0; bus.redirect_target = 16'h0; bus.ir_ready = 1'b0;
    chk("rdh_load", {bus.ir_valid, bus.pc_wr_en, bus.pc_src}, 3'b011);
    chk("rdh_pc_data", bus.pc_data, 16'h0040);
    tick();
    chk("rdh_settle1", {bus.imem_req, bus.pc_wr_en}, 0);
    tick();
    chk("rdh_settle2", {bus.imem_req, bus.pc_wr_en}, 0);
    do_fetch(16'h0040, 16'h5A5A, 0, 0);
    chk("rdh_no_inc", inc_cnt - n0, 1);

    // Redirect in FETCH: drain the late ack, then load; re-redirect in SETTLE
    wait_req();
    chk("rdf_addr", bus.imem_addr, 16'h0041);
    bus.redirect = 1'b1; bus.redirect_target = 16'h0100;
    tick();
    bus.redirect = 1'b0; bus.redirect_target = 16'h0;
    for (int k = 0; k < 3; k++) begin
      chk("rdf_drain", {bus.imem_req, bus.ir_valid, bus.pc_wr_en, bus.imem_addr},
          {3'b100, 16'h0041});
      if (k < 2) tick();
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'hDEAD;
    tick();
    bus.imem_ack = 1'b0; bus.imem_rdata = 16'h0;
    chk("rdf_load", {bus.ir_valid, bus.pc_wr_en, bus.pc_src, bus.imem_req}, 4'b0110);
    chk("rdf_pc_data", bus.pc_data, 16'h0100);
    tick();
    chk("rdf_settle", {bus.imem_req, bus.pc_wr_en}, 0);
    bus.redirect = 1'b1; bus.redirect_target = 16'h0200;
    tick();
    bus.redirect = 1'b0; bus.redirect_target = 16'h0;
    chk("rdf_reload", {bus.pc_wr_en, bus.pc_src, bus.pc_data}, {2'b11, 16'h0200});
    tick();
    chk("rdf_settle_b", {bus.imem_req, bus.pc_wr_en}, 0);
    do_fetch(16'h0200, 16'h1111, 1, 0);
    chk("dead_never_valid", dead_seen, 0);

    // Halt raised during FETCH
    wait_req();
    chk("halt_addr", bus.imem_addr, 16'h0201);
    bus.halt = 1'b1;
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'h2222;
    tick();
    bus.imem_ack = 1'b0;
    chk("halt_ir", {bus.ir_valid, bus.ir}, {1'b1, 16'h2222});
    bus.ir_ready = 1'b1;
    tick();
    bus.ir_ready = 1'b0;
    chk("halt_inc", {bus.pc_wr_en, bus.pc_src}, 2'b10);
    nreq = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (bus.imem_req) nreq++;
    end
    chk("halt_no_req", nreq, 0);
    bus.halt = 1'b0;
    do_fetch(16'h0202, 16'h3333, 0, 1);

    // Reset asserted mid-FETCH, stale ack afterwards
    wait_req();
    chk("rstf_addr", bus.imem_addr, 16'h0203);
    rst = 1'b0;
    #1;
    chk("rstf_drop", {bus.imem_req, bus.ir_valid, bus.imem_addr}, 0);
    tick();
    tick();
    bus.halt = 1'b1;
    rst = 1'b1;
    bus.imem_ack = 1'b1; bus.imem_rdata = 16'hBEEF;
    tick();
    bus.imem_ack = 1'b0; bus.imem_rdata = 16'h0;
    chk("rstf_late_ack", {bus.imem_req, bus.ir_valid, bus.ir}, 0);
    tick();
    chk("rstf_idle", {bus.imem_req, bus.ir_valid, bus.pc_wr_en}, 0);
    bus.halt = 1'b0;
    do_fetch(16'h0000, 16'h4444, 0, 0);

`ifdef FETCH_TIMEOUT_EN
    // Ack never arrives
    wait_req();
    chk("tmo_addr", bus.imem_addr, 16'h0001);
    bus.halt = 1'b1;
    nreq = 0;
    while (bus.imem_req && nreq < 20) begin
      nreq++;
      tick();
    end
    chk("tmo_req_cycles", nreq, 8);
    chk("tmo_err", bus.fetch_err, 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("tmo_idle", {bus.imem_req, bus.fetch_err, bus.pc_wr_en}, 3'b010);
    end
    bus.halt = 1'b0;
    do_fetch(16'h0001, 16'h6666, 0, 0);
    chk("tmo_err_sticky", bus.fetch_err, 1);
    rst = 1'b0;
    #1;
    chk("tmo_err_clear", bus.fetch_err, 0);
    tick();
    rst = 1'b1;
`else
    chk("fetch_err_tied", bus.fetch_err, 0);
`endif

    tick();
    chk("pc_protocol", viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
